// File: rtl/gbc_hdma_if.sv
// gbc_hdma_if: CPU register, source read and VRAM write signals of the GBC VRAM DMA engine
interface gbc_hdma_if;
  logic        ce;
  logic        isGBC;
  logic        cpu_sel_reg;
  logic [7:0]  cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic [1:0]  lcd_mode;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_di;
  logic [12:0] hdma_vram_addr;
  logic        hdma_vram_wren;
  logic [7:0]  hdma_vram_do;
  logic        hdma_active;
  modport master (
    input  ce, isGBC, cpu_sel_reg, cpu_addr, cpu_wr, cpu_di, lcd_mode, src_di,
    output cpu_do, src_addr, src_rd, hdma_vram_addr, hdma_vram_wren, hdma_vram_do, hdma_active
  );
  modport slave (
    output ce, isGBC, cpu_sel_reg, cpu_addr, cpu_wr, cpu_di, lcd_mode, src_di,
    input  cpu_do, src_addr, src_rd, hdma_vram_addr, hdma_vram_wren, hdma_vram_do, hdma_active
  );
endinterface

// File: rtl/gbc_hdma.sv
// gbc_hdma: GBC VRAM DMA (FF51-FF55, GDMA/HDMA); define GBC_HDMA_CANCEL_EN to allow HDMA cancel
module gbc_hdma #(
  parameter int BLOCK_BYTES = 16
) (
  input logic clk_sys,
  input logic reset,
  gbc_hdma_if.master bus
);
  localparam int BW = $clog2(BLOCK_BYTES);
`ifdef GBC_HDMA_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, RD, WR, HWAIT, HHOLD} state_t;
  state_t        r_state;
  logic [15:0]   r_src, r_src_cnt;
  logic [12:0]   r_dst, r_dst_cnt;
  logic [6:0]    r_len;
  logic [BW-1:0] r_byte;
  logic [1:0]    r_mode;
  logic          r_hdma, r_cancel, r_cpend;
  logic          w_wr, w_wr55, w_blk_end, w_hbl, w_cancel;
  assign w_wr      = bus.ce & bus.isGBC & bus.cpu_sel_reg & bus.cpu_wr;
  assign w_wr55    = w_wr & (bus.cpu_addr == 8'h55);
  assign w_blk_end = (r_state == WR) & (r_byte == BW'(BLOCK_BYTES - 1));
  assign w_hbl     = (bus.lcd_mode == 2'd0) & (r_mode != 2'd0);
  assign w_cancel  = CANCEL & w_wr55 & ~bus.cpu_di[7] & r_hdma & (r_state != IDLE);
  assign bus.src_addr       = r_src_cnt;
  assign bus.src_rd         = r_state == RD;
  assign bus.hdma_vram_addr = r_dst_cnt;
  assign bus.hdma_vram_wren = r_state == WR;
  assign bus.hdma_vram_do   = r_state == WR ? bus.src_di : 8'h00;
  assign bus.hdma_active    = (r_state == RD) | (r_state == WR);
  // register readback: only FF55 reports status, everything else reads FF
  always_comb begin
    bus.cpu_do = 8'h00;
    if (bus.cpu_sel_reg)
      bus.cpu_do = !(bus.isGBC && bus.cpu_addr == 8'h55) ? 8'hFF :
                   r_state != IDLE ? {1'b0, r_len} :
                   r_cancel ? {1'b1, r_len} : 8'hFF;
  end
  // shadow registers plus transfer FSM; counters load from the shadows only at start
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= IDLE;
      r_src     <= '0;
      r_src_cnt <= '0;
      r_dst     <= '0;
      r_dst_cnt <= '0;
      r_len     <= 7'h7F;
      r_byte    <= '0;
      r_mode    <= '0;
      r_hdma    <= 1'b0;
      r_cancel  <= 1'b0;
      r_cpend   <= 1'b0;
    end else if (bus.ce) begin
      r_mode <= bus.lcd_mode;
      if (w_wr && bus.cpu_addr == 8'h51) r_src[15:8] <= bus.cpu_di;
      if (w_wr && bus.cpu_addr == 8'h52) r_src[7:0] <= {bus.cpu_di[7:4], 4'h0};
      if (w_wr && bus.cpu_addr == 8'h53) r_dst[12:8] <= bus.cpu_di[4:0];
      if (w_wr && bus.cpu_addr == 8'h54) r_dst[7:0] <= {bus.cpu_di[7:4], 4'h0};
      case (r_state)
        IDLE: if (w_wr55) begin
          r_state   <= bus.cpu_di[7] ? HWAIT : RD;
          r_hdma    <= bus.cpu_di[7];
          r_len     <= bus.cpu_di[6:0];
          r_src_cnt <= r_src;
          r_dst_cnt <= r_dst;
          r_byte    <= '0;
          r_cancel  <= 1'b0;
          r_cpend   <= 1'b0;
        end
        RD: begin
          r_state <= WR;
          if (w_cancel) r_cpend <= 1'b1;
        end
        WR: begin
          r_src_cnt <= r_src_cnt + 16'd1;
          r_dst_cnt <= r_dst_cnt + 13'd1;
          r_byte    <= r_byte + 1'b1;
          if (!w_blk_end) begin
            r_state <= RD;
            if (w_cancel) r_cpend <= 1'b1;
          end else if (w_cancel) begin
            r_state  <= IDLE;
            r_cancel <= 1'b1;
          end else begin
            r_len    <= r_len - 7'd1;
            r_cancel <= r_cpend;
            r_state  <= (r_cpend || r_len == 7'd0) ? IDLE : r_hdma ? HHOLD : RD;
          end
        end
        HWAIT: begin
          r_state  <= w_cancel ? IDLE : w_hbl ? RD : HWAIT;
          r_cancel <= w_cancel;
        end
        HHOLD: begin
          r_state  <= w_cancel ? IDLE : bus.lcd_mode != 2'd0 ? HWAIT : HHOLD;
          r_cancel <= w_cancel;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gbc_hdma.sv
// tb_gbc_hdma: directed table-driven bench for gbc_hdma (GDMA table, HDMA, cancel, reset, isGBC)
module tb_gbc_hdma;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  gbc_hdma_if bus();
  gbc_hdma #(.BLOCK_BYTES(16)) dut (.clk_sys(clk_sys), .reset(reset), .bus(bus.master));

  typedef struct {
    logic [7:0]  sh, sl, dh, dl;
    logic [6:0]  len;
    logic [15:0] es;
    logic [12:0] ed;
  } vec_t;

  int checks = 0, errors = 0;
  int nw = 0, ns = 0, nact = 0;
  logic [12:0] la [0:255];
  logic [7:0]  ld [0:255];
  logic [15:0] ls [0:255];

  always #5 clk_sys = ~clk_sys;

  initial begin
    bus.ce = 1'b0;
    forever begin
      @(posedge clk_sys);
      #2 bus.ce = ~bus.ce;
    end
  end

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]};
  endfunction

  always @(posedge clk_sys) if (bus.ce && bus.src_rd) bus.src_di <= mem(bus.src_addr);

  always @(negedge clk_sys) if (bus.ce) begin
    if (bus.hdma_vram_wren) begin
      if (nw < 256) begin
        la[nw] = bus.hdma_vram_addr;
        ld[nw] = bus.hdma_vram_do;
      end
      nw++;
    end
    if (bus.src_rd) begin
      if (ns < 256) ls[ns] = bus.src_addr;
      ns++;
    end
    if (bus.hdma_active) nact++;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic ce_tick();
    @(posedge clk_sys);
    while (!bus.ce) @(posedge clk_sys);
    #1;
  endtask

  task automatic wreg(input logic [7:0] a, input logic [7:0] d);
    bus.cpu_sel_reg = 1'b1;
    bus.cpu_wr = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_di = d;
    ce_tick();
    bus.cpu_sel_reg = 1'b0;
    bus.cpu_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    bus.cpu_sel_reg = 1'b1;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = a;
    #1 v = bus.cpu_do;
    bus.cpu_sel_reg = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    for (int k = 0; k < budget && bus.hdma_active; k++) ce_tick();
    chk("idle_timeout", bus.hdma_active, 1'b0);
  endtask

  task automatic hblank(input logic exp_rd);
    bus.lcd_mode = 2'd2;
    repeat (3) ce_tick();
    bus.lcd_mode = 2'd3;
    repeat (3) ce_tick();
    bus.lcd_mode = 2'd0;
    ce_tick();
    chk("hblank_rd", bus.src_rd, exp_rd);
    repeat (40) ce_tick();
    chk("hblank_quiet", bus.hdma_active, 1'b0);
  endtask

  task automatic set_addr(input logic [7:0] sh, sl, dh, dl);
    wreg(8'h51, sh);
    wreg(8'h52, sl);
    wreg(8'h53, dh);
    wreg(8'h54, dl);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v [4];
    logic [7:0] r;
    logic [7:0] exp55 [3];
    int nb, bad, n0;
    v[0] = '{8'hC0, 8'h00, 8'h80, 8'h00, 7'd0, 16'hC000, 13'h0000};
    v[1] = '{8'h12, 8'h3F, 8'h84, 8'h5A, 7'd2, 16'h1230, 13'h0450};
    v[2] = '{8'hFF, 8'hF8, 8'h9F, 8'hF0, 7'd1, 16'hFFF0, 13'h1FF0};
    v[3] = '{8'h00, 8'h07, 8'hFF, 8'hFF, 7'd0, 16'h0000, 13'h1FF0};
    exp55[0] = 8'h01;
    exp55[1] = 8'h00;
    exp55[2] = 8'hFF;
    bus.isGBC = 1'b1;
    bus.cpu_sel_reg = 1'b0;
    bus.cpu_addr = 8'h00;
    bus.cpu_wr = 1'b0;
    bus.cpu_di = 8'h00;
    bus.lcd_mode = 2'd2;
    repeat (4) ce_tick();
    chk("reset_outputs", {bus.src_rd, bus.hdma_vram_wren, bus.hdma_active, bus.src_addr,
                          bus.hdma_vram_addr, bus.hdma_vram_do}, 0);
    rd(8'h55, r);
    chk("reset_ff55", r, 8'hFF);
    reset = 1'b0;
    ce_tick();
    for (int i = 0; i < 4; i++) begin
      set_addr(v[i].sh, v[i].sl, v[i].dh, v[i].dl);
      nw = 0; ns = 0; nact = 0;
      wreg(8'h55, {1'b0, v[i].len});
      chk("gdma_start_rd", bus.src_rd, 1'b1);
      run_idle(2000);
      nb = 16 * (int'(v[i].len) + 1);
      chk("gdma_writes", nw, nb);
      chk("gdma_active_ce", nact, 2 * nb);
      bad = 0;
      for (int k = 0; k < nb; k++)
        if (la[k] !== 13'(v[i].ed + 13'(k)) || ld[k] !== mem(16'(v[i].es + 16'(k))) ||
            ls[k] !== 16'(v[i].es + 16'(k))) bad++;
      chk("gdma_data", bad, 0);
      if (i == 2) begin
        chk("wrap_dst_1fff", la[15], 13'h1FFF);
        chk("wrap_dst_0000", la[16], 13'h0000);
        chk("wrap_src_ffff", ls[15], 16'hFFFF);
        chk("wrap_src_0000", ls[16], 16'h0000);
      end
      rd(8'h55, r);
      chk("gdma_ff55", r, 8'hFF);
    end
    rd(8'h51, r);
    chk("ff51_read", r, 8'hFF);
    rd(8'h53, r);
    chk("ff53_read", r, 8'hFF);
    set_addr(8'hC0, 8'h00, 8'h80, 8'h00);
    bus.lcd_mode = 2'd0;
    repeat (2) ce_tick();
    nw = 0; ns = 0; nact = 0;
    wreg(8'h55, 8'h82);
    repeat (10) ce_tick();
    chk("hdma_wait_mode0", nw, 0);
    rd(8'h55, r);
    chk("hdma_pending_ff55", r, 8'h02);
    for (int b = 0; b < 3; b++) begin
      hblank(1'b1);
      chk("hdma_block_writes", nw, 16 * (b + 1));
      rd(8'h55, r);
      chk("hdma_ff55", r, exp55[b]);
    end
    chk("hdma_active_ce", nact, 96);
    bad = 0;
    for (int k = 0; k < 48; k++)
      if (la[k] !== 13'(k) || ld[k] !== mem(16'hC000 + 16'(k))) bad++;
    chk("hdma_data", bad, 0);
    nw = 0;
    wreg(8'h55, 8'h85);
    hblank(1'b1);
    hblank(1'b1);
    chk("cancel_pre_writes", nw, 32);
    wreg(8'h55, 8'h00);
    rd(8'h55, r);
`ifdef GBC_HDMA_CANCEL_EN
    chk("cancel_ff55", r, 8'h83);
    for (int b = 0; b < 4; b++) hblank(1'b0);
    chk("cancel_writes", nw, 32);
    rd(8'h55, r);
    chk("cancel_ff55_after", r, 8'h83);
`else
    chk("nocancel_ff55", r, 8'h03);
    for (int b = 0; b < 4; b++) hblank(1'b1);
    chk("nocancel_writes", nw, 96);
    rd(8'h55, r);
    chk("nocancel_ff55_after", r, 8'hFF);
`endif
    set_addr(8'hC0, 8'h00, 8'h80, 8'h00);
    nw = 0;
    wreg(8'h55, 8'h00);
    repeat (9) ce_tick();
    chk("rst_in_wr", bus.hdma_vram_wren, 1'b1);
    chk("rst_wr_addr", bus.hdma_vram_addr, 13'h0004);
    reset = 1'b1;
    ce_tick();
    n0 = nw;
    chk("rst_mid_outputs", {bus.src_rd, bus.hdma_vram_wren, bus.hdma_active, bus.src_addr,
                            bus.hdma_vram_addr, bus.hdma_vram_do}, 0);
    rd(8'h55, r);
    chk("rst_mid_ff55", r, 8'hFF);
    reset = 1'b0;
    repeat (20) ce_tick();
    chk("rst_no_more_writes", nw, n0);
    bus.isGBC = 1'b0;
    n0 = nw;
    wreg(8'h55, 8'h00);
    repeat (10) ce_tick();
    chk("nogbc_no_transfer", {nw == n0, bus.src_rd, bus.hdma_active}, 3'b100);
    rd(8'h55, r);
    chk("nogbc_ff55", r, 8'hFF);
    bus.isGBC = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
